seg_display_arbiter: RTL and testbench

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

---
 rtl/seg_display_arbiter.sv | 157 +++++++++++++++
 tb/tb_seg_display_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - two-source 7-segment display arbiter with minimum dwell; optional BLANK_IDLE_EN blanks digits in IDLE
module seg_display_arbiter #(
    parameter int DWELL = 25000000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic [6:0]  out1A,
    output logic [6:0]  out2A,
    output logic [6:0]  out3A,
    output logic [6:0]  out4A
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW0 = 2'd1,
        SHOW1 = 2'd2
    } state_t;

    // Count value on which a SHOW state makes its stay/switch/release decision.
    localparam logic [25:0] DWELL_LAST = 26'(DWELL - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t      state;
    logic [25:0] count;
    logic [15:0] value;
    logic        last_served;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Arbitration FSM: owns state, dwell counter, value register and fairness pointer.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            count       <= '0;
            value       <= 16'h0000;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // With both requesting, the source not served last wins.
                    if (req0 && (!req1 || last_served)) begin
                        state       <= SHOW0;
                        value       <= data0;
                        count       <= '0;
                        last_served <= 1'b0;
                    end else if (req1) begin
                        state       <= SHOW1;
                        value       <= data1;
                        count       <= '0;
                        last_served <= 1'b1;
                    end
                end
                SHOW0: begin
                    if (req0) begin
                        value <= data0;
                    end
                    if (count == DWELL_LAST) begin
                        if (req1) begin
                            state       <= SHOW1;
                            value       <= data1;
                            count       <= '0;
                            last_served <= 1'b1;
                        end else if (req0) begin
                            count <= '0;
                        end else begin
                            state <= IDLE;
                            count <= '0;
                        end
                    end else begin
                        count <= count + 26'd1;
                    end
                end
                SHOW1: begin
                    if (req1) begin
                        value <= data1;
                    end
                    if (count == DWELL_LAST) begin
                        if (req0) begin
                            state       <= SHOW0;
                            value       <= data0;
                            count       <= '0;
                            last_served <= 1'b0;
                        end else if (req1) begin
                            count <= '0;
                        end else begin
                            state <= IDLE;
                            count <= '0;
                        end
                    end else begin
                        count <= count + 26'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // Grants come straight from the registered state so they can never overlap.
    assign gnt0 = (state == SHOW0);
    assign gnt1 = (state == SHOW1);
    assign busy = gnt0 | gnt1;

    // Digit decode of the value register; optionally blanked while nobody owns the display.
    always_comb begin
        out1A = seg_decode(value[15:12]);
        out2A = seg_decode(value[11:8]);
        out3A = seg_decode(value[7:4]);
        out4A = seg_decode(value[3:0]);
`ifdef BLANK_IDLE_EN
        if (state == IDLE) begin
            out1A = SEG_BLANK;
            out2A = SEG_BLANK;
            out3A = SEG_BLANK;
            out4A = SEG_BLANK;
        end
`endif
    end

`ifndef BLANK_IDLE_EN
    logic unused_blank;
    assign unused_blank = ^SEG_BLANK;
`endif

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - self-checking bench for seg_display_arbiter with DWELL=4
module tb_seg_display_arbiter;

    localparam int DWELL = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [15:0] data0 = '0;
    logic [15:0] data1 = '0;
    logic        gnt0, gnt1, busy;
    logic [6:0]  out1A, out2A, out3A, out4A;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_display_arbiter #(.DWELL(DWELL)) dut (
        .Clk(Clk), .Rst(Rst),
        .req0(req0), .data0(data0),
        .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .out1A(out1A), .out2A(out2A), .out3A(out3A), .out4A(out4A)
    );

    always #5 Clk = ~Clk;

    // Reference model: who owns the display, how many cycles of the grant remain.
    int          m_owner = -1;
    int          m_left  = 0;
    int          m_last  = 1;
    logic [15:0] m_val   = '0;

    function automatic logic [27:0] digits(input logic [15:0] v);
        return {SEG[v[15:12]], SEG[v[11:8]], SEG[v[7:4]], SEG[v[3:0]]};
    endfunction

    function automatic logic [27:0] idle_digits(input logic [15:0] v);
`ifdef BLANK_IDLE_EN
        return {4{7'b1111111}};
`else
        return digits(v);
`endif
    endfunction

    function automatic logic [30:0] model_expect();
        logic [27:0] d;
        d = (m_owner < 0) ? idle_digits(m_val) : digits(m_val);
        return {m_owner == 0, m_owner == 1, m_owner >= 0, d};
    endfunction

    task automatic model_enter(input int n);
        m_owner = n;
        m_left  = DWELL;
        m_val   = (n == 0) ? data0 : data1;
        m_last  = n;
    endtask

    task automatic model_step();
        logic r [2];
        r[0] = req0;
        r[1] = req1;
        if (Rst) begin
            m_owner = -1;
            m_val   = 16'h0000;
            m_last  = 1;
        end else if (m_owner < 0) begin
            if (r[0] && r[1]) model_enter(1 - m_last);
            else if (r[0])    model_enter(0);
            else if (r[1])    model_enter(1);
        end else begin
            if (r[m_owner]) m_val = (m_owner == 0) ? data0 : data1;
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (r[1 - m_owner])  model_enter(1 - m_owner);
                else if (r[m_owner]) m_left = DWELL;
                else                 m_owner = -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        tick();
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_grants: got %b want 000", {gnt0, gnt1, busy});
        end
        n_checks++;
        if ({out1A, out2A, out3A, out4A} !== idle_digits(16'h0000)) begin
            n_fail++;
            $display("FAIL reset_digits: got %h want %h", {out1A, out2A, out3A, out4A}, idle_digits(16'h0000));
        end
    endtask

    task automatic test_single();
        do_reset();
        req0 = 1'b1; data0 = 16'h12A5;
        tick();
        n_checks++;
        if ({gnt0, gnt1, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL single_grant: got %b want 101", {gnt0, gnt1, busy});
        end
        n_checks++;
        if ({out1A, out2A, out3A, out4A} !== {7'b1111001, 7'b0100100, 7'b0001000, 7'b0010010}) begin
            n_fail++;
            $display("FAIL single_digits: got %b %b %b %b want 1111001 0100100 0001000 0010010",
                     out1A, out2A, out3A, out4A);
        end
        req0 = 1'b0;
        repeat (DWELL) tick();
    endtask

    task automatic test_alternate();
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        data0 = 16'h0000; data1 = 16'hFFFF;
        for (int i = 0; i < 4 * DWELL; i++) begin
            logic want0;
            tick();
            want0 = ((i / DWELL) % 2) == 0;
            n_checks++;
            if ({gnt0, gnt1} !== {want0, !want0}) begin
                n_fail++;
                $display("FAIL alternate_cycle%0d: got %b want %b", i, {gnt0, gnt1}, {want0, !want0});
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (DWELL) tick();
    endtask

    task automatic test_pulse();
        int held;
        logic [27:0] frozen;
        frozen = {7'b0000000, 7'b0001110, 7'b1000000, 7'b1000000};
        do_reset();
        req0 = 1'b1; data0 = 16'h8F00;
        tick();
        req0 = 1'b0; data0 = 16'h1234;
        held = gnt0 ? 1 : 0;
        for (int i = 0; i < 2 * DWELL; i++) begin
            tick();
            if (gnt0) held++;
            n_checks++;
            if ({out1A, out2A, out3A, out4A} !== (gnt0 ? frozen : idle_digits(16'h8F00))) begin
                n_fail++;
                $display("FAIL pulse_digits_cycle%0d: got %h want %h", i, {out1A, out2A, out3A, out4A},
                         gnt0 ? frozen : idle_digits(16'h8F00));
            end
        end
        n_checks++;
        if (held !== DWELL) begin
            n_fail++;
            $display("FAIL pulse_length: got %0d cycles want %0d", held, DWELL);
        end
    endtask

    task automatic test_reset_mid();
        int held;
        do_reset();
        req1 = 1'b1; data1 = 16'h5A5A;
        tick();
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0; req1 = 1'b0;
        n_checks++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_grants: got %b want 000", {gnt0, gnt1, busy});
        end
        n_checks++;
        if ({out1A, out2A, out3A, out4A} !== idle_digits(16'h0000)) begin
            n_fail++;
            $display("FAIL midreset_digits: got %h want %h", {out1A, out2A, out3A, out4A}, idle_digits(16'h0000));
        end
        req1 = 1'b1;
        tick();
        req1 = 1'b0;
        held = gnt1 ? 1 : 0;
        for (int i = 0; i < 2 * DWELL; i++) begin
            tick();
            if (gnt1) held++;
        end
        n_checks++;
        if (held !== DWELL) begin
            n_fail++;
            $display("FAIL midreset_regrant: got %0d cycles want %0d", held, DWELL);
        end
    endtask

    task automatic test_random();
        logic [30:0] want;
        for (int i = 0; i < 600; i++) begin
            Rst   = ($urandom_range(0, 59) == 0);
            req0  = ($urandom_range(0, 2) != 0);
            req1  = ($urandom_range(0, 2) == 0);
            data0 = 16'($urandom);
            data1 = 16'($urandom);
            tick();
            want = model_expect();
            n_checks++;
            if ({gnt0, gnt1, busy, out1A, out2A, out3A, out4A} !== want) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %b want %b", i,
                         {gnt0, gnt1, busy, out1A, out2A, out3A, out4A}, want);
            end
            n_checks++;
            if (gnt0 && gnt1) begin
                n_fail++;
                $display("FAIL random_exclusive%0d: got gnt0=1 gnt1=1 want at most one", i);
            end
        end
        Rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_pulse();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
